// File: rtl/stream_mux_rr_pkg.sv
// Shared constants and helpers for the round-robin streaming multiplexer.
package stream_mux_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  // Next channel index after idx, wrapping n-1 -> 0 by compare so that
  // non-power-of-two channel counts never land on a phantom index.
  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_mux_rr_if.sv
// Handshake/data bundle between the producers, the multiplexer and the consumer.
interface stream_mux_rr_if #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
);
  localparam int SELW = $clog2(NCH);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;

  // Producer/consumer side: drives inputs, select and the consumer ready.
  modport master (
    output in_data, in_valid, sel, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  // Multiplexer side.
  modport slave (
    input  in_data, in_valid, sel, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );

endinterface

// File: rtl/stream_mux_rr_arbiter.sv
// Rotate-priority arbiter: the channel after ptr has highest priority,
// ptr itself the lowest. Purely combinational.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int NCH  = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  logic [SELW-1:0] idx;

  // Walk the channels starting just after ptr; first requester wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = ptr;
    for (int i = 0; i < NCH; i++) begin
      idx = SELW'(next_idx(int'(idx), NCH));
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Selection is either an external select or round-robin arbitration.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  parameter  int MODE  = MODE_RR,
  localparam int SELW  = $clog2(NCH)
) (
  input logic            clk,
  input logic            rst_n,
  stream_mux_rr_if.slave bus
);

  localparam logic [SELW:0] NCH_W = (SELW + 1)'(NCH);

  logic             load_en;
  logic             gnt_valid;
  logic [SELW-1:0]  gnt_idx;
  logic             accept;
  logic [WIDTH-1:0] chan_word [NCH];

  // The output register can take a word when it is empty or being drained.
  assign load_en = !bus.out_valid || bus.out_ready;
  assign accept  = |(bus.in_valid & bus.in_ready);

  // Split the flat input bus into per-channel words.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      chan_word[k] = bus.in_data[k*WIDTH +: WIDTH];
    end
  end

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] rr_ptr;

      rr_arbiter #(.NCH(NCH)) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
      );

      // Pointer remembers the last accepted channel; it only moves on a transfer.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rr_ptr <= SELW'(NCH - 1);
        end else if (accept) begin
          rr_ptr <= gnt_idx;
        end
      end
    end else begin : g_sel
      // External select; an out-of-range select simply never grants.
      always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = bus.sel;
        if ({1'b0, bus.sel} < NCH_W) begin
          gnt_valid = bus.in_valid[bus.sel];
        end
      end
    end
  endgenerate

  // At most one ready bit, only when the output stage can load and not in reset.
  always_comb begin
    bus.in_ready = '0;
    if (rst_n && load_en && gnt_valid) begin
      bus.in_ready[gnt_idx] = 1'b1;
    end
  end

  // One-entry output register: load replaces, drain empties, stall holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
    end else if (load_en) begin
      if (accept) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= chan_word[gnt_idx];
        bus.out_ch    <= gnt_idx;
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
